// File: rtl/im_pipe.sv
// Instruction memory with byte-enabled loader port, optional zero fill after
// reset, and an RD_LAT-deep stallable/flushable fetch pipeline.
module im_pipe #(
  parameter int DEPTH          = 2048,
  parameter int ADDR_W         = 16,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              en,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  output logic              resp_valid,
  output logic [31:0]       resp_inst,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err,
  output logic              init_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  // Wide compare so DEPTH == 2**ADDR_W never wraps
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_V);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W-1:0];
  endfunction

  logic [31:0]       mem [DEPTH];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IDX_W-1:0]  clr_ptr_r;
  logic [IDX_W-1:0]  clr_ptr_nxt_s;
  logic              clr_we_s;
  logic              init_done_r;

  logic              accept_s;
  logic              wr_ok_s;
  logic              rd_in_range_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [31:0]       rd_word_s;

  logic              st_valid_r [RD_LAT];
  logic [31:0]       st_inst_r  [RD_LAT];
  logic [ADDR_W-1:0] st_addr_r  [RD_LAT];
  logic              st_err_r   [RD_LAT];

  // FSM state, fill pointer and ready flag registers
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_r     <= RESET_STATE;
      clr_ptr_r   <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      clr_ptr_r   <= clr_ptr_nxt_s;
      init_done_r <= (state_nxt_s == ST_READY);
    end
  end

  // FSM next state: walk the fill pointer once across the array
  always_comb begin
    state_nxt_s   = state_r;
    clr_ptr_nxt_s = clr_ptr_r;
    clr_we_s      = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_ptr_r == LAST_IDX) begin
          state_nxt_s   = ST_READY;
          clr_ptr_nxt_s = '0;
        end else begin
          clr_ptr_nxt_s = clr_ptr_r + IDX_W'(1);
        end
      end
      ST_READY: begin
        state_nxt_s = ST_READY;
      end
      default: begin
        state_nxt_s   = RESET_STATE;
        clr_ptr_nxt_s = '0;
      end
    endcase
  end

  assign init_done = init_done_r;
  assign req_ready = init_done_r & en;
  assign accept_s  = req_valid & req_ready & ~flush;
  assign wr_ok_s   = wr_en & init_done_r & ~cpu_rst & in_range(wr_addr);

  // Read address decode; out-of-range fetches never touch the array
  always_comb begin
    rd_in_range_s = in_range(req_addr);
    rd_idx_s      = '0;
    rd_word_s     = 32'd0;
    if (rd_in_range_s) begin
      rd_idx_s  = to_idx(req_addr);
      rd_word_s = mem[rd_idx_s];
    end else begin
      rd_idx_s  = '0;
      rd_word_s = 32'd0;
    end
  end

  // Memory array: zero fill in CLEAR, byte-enabled loader writes in READY
  always_ff @(posedge cpu_clk_50M) begin
    if (clr_we_s && !cpu_rst) begin
      mem[clr_ptr_r] <= 32'd0;
    end else if (wr_ok_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[to_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Fetch pipeline; data moves only with a valid bit so resp_* hold when idle
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        st_valid_r[i] <= 1'b0;
        st_inst_r[i]  <= 32'd0;
        st_addr_r[i]  <= '0;
        st_err_r[i]   <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < RD_LAT; i++) begin
        st_valid_r[i] <= 1'b0;
      end
    end else if (en) begin
      st_valid_r[0] <= accept_s;
      if (accept_s) begin
        st_inst_r[0] <= rd_word_s;
        st_addr_r[0] <= req_addr;
        st_err_r[0]  <= ~rd_in_range_s;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        st_valid_r[i] <= st_valid_r[i-1];
        if (st_valid_r[i-1]) begin
          st_inst_r[i] <= st_inst_r[i-1];
          st_addr_r[i] <= st_addr_r[i-1];
          st_err_r[i]  <= st_err_r[i-1];
        end
      end
    end
  end

  assign resp_valid = st_valid_r[RD_LAT-1];
  assign resp_inst  = st_inst_r[RD_LAT-1];
  assign resp_addr  = st_addr_r[RD_LAT-1];
  assign resp_err   = st_err_r[RD_LAT-1];

endmodule
